// File: rtl/mux_stream_sched.sv
// Skewed release sequencer for the systolic-array input stream muxes.
// Optional abort port pair is enabled by defining MUX_SCHED_ABORT_EN.
module mux_stream_sched #(
  parameter int unsigned N_LANES   = 4,
  parameter int unsigned BLOCK_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         blocks,
  input  logic               hold,
`ifdef MUX_SCHED_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic [N_LANES-1:0] lane_rst,
  output logic [N_LANES-1:0] lane_last,
  output logic               step,
  output logic               busy,
  output logic               done
);

  localparam int unsigned      K_W    = $clog2(BLOCK_LEN);
  localparam logic [K_W-1:0]   K_LAST = K_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] BLK_C  = CNT_W'(BLOCK_LEN);
  localparam logic [CNT_W-1:0] TAIL_C = CNT_W'(N_LANES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   t_q, t_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [7:0]         nblk_q, nblk_d;
  logic [N_LANES-1:0] lane_rst_q, lane_rst_d;
  logic [N_LANES-1:0] lane_last_q, lane_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_c;
  logic               adv;
  logic               f0;
  logic [CNT_W-1:0]   len_q, len_d, last_t;

`ifdef MUX_SCHED_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_c = abort;
  assign aborted = aborted_q;

  always_comb begin
    aborted_d = (state_q == S_RUN) && abort_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= aborted_d;
  end
`else
  assign abort_c = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    k_d         = k_q;
    nblk_d      = nblk_q;
    lane_last_d = lane_last_q;
    done_d      = 1'b0;
    adv         = 1'b0;
    f0          = 1'b0;
    len_q       = CNT_W'(nblk_q) * BLK_C;
    last_t      = len_q + TAIL_C - CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (blocks == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            nblk_d  = blocks;
            t_d     = '0;
            k_d     = '0;
          end
        end
      end
      S_RUN: begin
        // abort overrides both hold and the natural end of the run
        if (abort_c) begin
          state_d = S_IDLE;
          t_d     = '0;
          k_d     = '0;
        end else if (!hold) begin
          if (t_q == last_t) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            t_d     = '0;
            k_d     = '0;
          end else begin
            adv = 1'b1;
            t_d = t_q + CNT_W'(1);
            k_d = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    len_d  = CNT_W'(nblk_d) * BLK_C;
    busy_d = (state_d == S_RUN);

    // lane i streams while i <= t < i + nblk*BLOCK_LEN
    for (int i = 0; i < int'(N_LANES); i++) begin
      lane_rst_d[i] = !(busy_d && (t_d >= CNT_W'(i)) && ((t_d - CNT_W'(i)) < len_d));
    end

    // lane 0 flush flag, delayed one advancing beat per lane
    if (state_d != S_RUN || state_q != S_RUN) begin
      lane_last_d = '0;
    end else if (adv) begin
      f0 = (t_d < len_d) && (k_d == K_LAST);
      lane_last_d[0] = f0;
      for (int i = 1; i < int'(N_LANES); i++) begin
        lane_last_d[i] = lane_last_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      k_q         <= '0;
      nblk_q      <= '0;
      lane_rst_q  <= '1;
      lane_last_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      k_q         <= k_d;
      nblk_q      <= nblk_d;
      lane_rst_q  <= lane_rst_d;
      lane_last_q <= lane_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign lane_rst  = lane_rst_q;
  assign lane_last = lane_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step      = busy_q & ~hold;

endmodule
